// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, bout set when the bit underflows.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first through one full_subtractor cell.
// Define SUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
`ifdef SUB_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic fs_d;
    logic fs_bout;

    full_subtractor u_fs (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .bin  (borrow_q),
        .d    (fs_d),
        .bout (fs_bout)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        borrow_d    = borrow_q;
        diff_d      = diff_q;
        bout_d      = bout_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
`ifdef SUB_OVF_EN
        ovf_d       = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sh_d     = a;
                    b_sh_d     = b;
                    borrow_d   = bin;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                borrow_d = fs_bout;
                diff_d   = {fs_d, diff_q[WIDTH-1:1]};
                if (cnt_q == LAST_BIT) begin
                    // On the last bit the shift-register LSBs hold the operand MSBs.
                    bout_d      = fs_bout;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
`ifdef SUB_OVF_EN
                    ovf_d = (a_sh_q[0] ^ b_sh_q[0]) & (a_sh_q[0] ^ fs_d);
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            borrow_q    <= 1'b0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef SUB_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            borrow_q    <= borrow_d;
            diff_q      <= diff_d;
            bout_q      <= bout_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef SUB_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign bout      = bout_q;
`ifdef SUB_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial two's-complement subtractor computing a − b − bin over WIDTH cycles, one bit per cycle, through a single full-subtractor cell and a borrow flop. It is the area-minimal inverse of the team's combinational ripple-carry adder, intended for datapaths where latency is cheap and gates are not. Operands enter and the result leaves through valid/ready handshakes, so the block drops into streaming pipelines.

## Interface
Parameters:
- WIDTH, 4, operand and result width in bits; legal range WIDTH ≥ 2.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operand bundle valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow-in.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- diff  output  WIDTH  a − b − bin, modulo 2^WIDTH.
- bout  output  1  borrow-out; 1 when unsigned a < b + bin.
- ovf  output  1  signed overflow; present only with SUB_OVF_EN.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: in_ready = 1. If in_valid is high, latch a, b, bin into the shift registers, clear the bit counter, and go to SHIFT.
- SHIFT: in_ready = 0. Each cycle processes bit i = counter, LSB first:
  - d_i = a_i ^ b_i ^ borrow.
  - borrow' = (~a_i & b_i) | (~(a_i ^ b_i) & borrow).
  - d_i shifts into the diff register from the MSB end.
  - The counter increments. After the cycle with counter = WIDTH−1, go to DONE.
- DONE: out_valid = 1. diff, bout (the final borrow) and ovf are stable. When out_ready is high, go to IDLE.
- in_valid is ignored outside IDLE. Operands are sampled only on the accept edge; changing a, b or bin later has no effect.
- ovf = (a_msb ^ b_msb) & (a_msb ^ diff_msb), using the latched a and b.
- The bit counter is $clog2(WIDTH) bits wide and never wraps past WIDTH−1.
- No arithmetic width extension: the result is exactly WIDTH bits plus bout.

## Timing
- Reset (rst_n low at a rising edge):
  - State goes to IDLE.
  - in_ready = 1; out_valid = 0; diff = 0; bout = 0; ovf = 0.
  - The counter and borrow flop are cleared.
- Reset mid-SHIFT or mid-DONE aborts the operation. The result is discarded and no out_valid pulse appears.
- Latency: out_valid rises exactly WIDTH cycles after the accept edge.
- Throughput: one result per WIDTH+2 cycles when out_ready is held high. There is one DONE cycle, then one IDLE cycle.
- The accept handshake and the result handshake never occur in the same cycle.
- Backpressure: DONE holds indefinitely while out_ready is low. diff, bout and ovf must not change during the hold.
- Outputs are registered. There is no combinational path from any input to any output.

## Configuration
- SUB_OVF_EN defined:
  - The ovf port and its register exist.
  - ovf is registered on the DONE transition and cleared by reset.
- SUB_OVF_EN undefined:
  - The ovf port and its logic are absent.
  - All other behaviour is identical cycle for cycle.

## Structure
- Package serial_sub_pkg contains:
  - the state enum (IDLE, SHIFT, DONE);
  - the default WIDTH constant.
- Sub-module full_subtractor has ports a, b, bin, d, bout and is purely combinational. It is instantiated once and fed from the LSB of the operand shift registers and the borrow flop.
- The top level holds the FSM, the counter, the shift registers and the output registers.

## Test plan
All scenarios use WIDTH = 4.
- Basic: a=9, b=3, bin=0 -> diff=6, bout=0; out_valid rises 4 cycles after the accept edge.
- Borrow: a=3, b=9, bin=0 -> diff=0xA, bout=1.
- Borrow-in edge: a=0, b=0, bin=1 -> diff=0xF, bout=1. Then a=0xF, b=0xF, bin=0 -> diff=0, bout=0.
- Overflow (SUB_OVF_EN): a=0x7, b=0x8 -> diff=0xF, bout=1, ovf=1. Then a=0x8, b=0x1 -> diff=0x7, ovf=1. Then a=5, b=2 -> ovf=0.
- Backpressure: hold out_ready low for 10 cycles in DONE -> outputs are stable and in_ready=0 throughout; in_valid pulses are ignored. Release -> IDLE the next cycle, then the next operand is accepted.
- Reset mid-operation: assert rst_n low at SHIFT bit 2 -> the next edge shows in_ready=1, out_valid=0, diff=0. A fresh 9−3 then completes correctly with diff=6.
